// File: rtl/dac_wave_gen.sv
// rtl/dac_wave_gen.sv - phase-accumulator waveform source for the PMOD DAC byte
// Optional sine waveform (code 3) built when DAC_SINE_LUT_EN is defined.
module dac_wave_gen #(
  parameter int SAMPLE_DIV = 250
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Wave_Next,
  input  logic [7:0] i_Freq_Step,
  output logic [7:0] o_Sample,
  output logic       o_Sample_Valid,
  output logic [1:0] o_Wave_Sel
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

`ifdef DAC_SINE_LUT_EN
  localparam logic [1:0] SEL_LAST = 2'd3;

  function automatic logic [6:0] sine_lut(input logic [5:0] k);
    logic [6:0] v;
    v = 7'd0;
    case (k)
      6'd0:  v = 7'd2;   6'd1:  v = 7'd5;   6'd2:  v = 7'd8;   6'd3:  v = 7'd11;
      6'd4:  v = 7'd14;  6'd5:  v = 7'd17;  6'd6:  v = 7'd20;  6'd7:  v = 7'd23;
      6'd8:  v = 7'd26;  6'd9:  v = 7'd29;  6'd10: v = 7'd32;  6'd11: v = 7'd35;
      6'd12: v = 7'd38;  6'd13: v = 7'd41;  6'd14: v = 7'd44;  6'd15: v = 7'd47;
      6'd16: v = 7'd50;  6'd17: v = 7'd53;  6'd18: v = 7'd56;  6'd19: v = 7'd58;
      6'd20: v = 7'd61;  6'd21: v = 7'd64;  6'd22: v = 7'd67;  6'd23: v = 7'd69;
      6'd24: v = 7'd72;  6'd25: v = 7'd74;  6'd26: v = 7'd77;  6'd27: v = 7'd79;
      6'd28: v = 7'd82;  6'd29: v = 7'd84;  6'd30: v = 7'd86;  6'd31: v = 7'd89;
      6'd32: v = 7'd91;  6'd33: v = 7'd93;  6'd34: v = 7'd95;  6'd35: v = 7'd97;
      6'd36: v = 7'd99;  6'd37: v = 7'd101; 6'd38: v = 7'd103; 6'd39: v = 7'd105;
      6'd40: v = 7'd106; 6'd41: v = 7'd108; 6'd42: v = 7'd110; 6'd43: v = 7'd111;
      6'd44: v = 7'd113; 6'd45: v = 7'd114; 6'd46: v = 7'd115; 6'd47: v = 7'd117;
      6'd48: v = 7'd118; 6'd49: v = 7'd119; 6'd50: v = 7'd120; 6'd51: v = 7'd121;
      6'd52: v = 7'd122; 6'd53: v = 7'd123; 6'd54: v = 7'd124; 6'd55: v = 7'd124;
      6'd56: v = 7'd125; 6'd57: v = 7'd125; 6'd58: v = 7'd126; 6'd59: v = 7'd126;
      default: v = 7'd127;
    endcase
    return v;
  endfunction
`else
  localparam logic [1:0] SEL_LAST = 2'd2;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      phase_q, phase_d;
  logic [1:0]       sel_q, sel_d;
  logic             prev_q;
  logic             tick_d1_q;
  logic [7:0]       sample_q, sample_d;
  logic             valid_q;

  logic             tick;
  logic             wave_edge;
  logic [7:0]       p;
  logic [7:0]       shape;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    phase_d   = tick ? phase_q + {8'h00, i_Freq_Step} : phase_q;
    wave_edge = i_Wave_Next & ~prev_q;
    sel_d     = sel_q;
    if (wave_edge) begin
      sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
    end
  end

  // Shaping uses the phase and select held in the cycle after the tick.
  always_comb begin
    p     = phase_q[15:8];
    shape = 8'h00;
    case (sel_q)
      2'd0: shape = p;
      2'd1: shape = phase_q[15] ? ~{phase_q[14:8], 1'b0} : {phase_q[14:8], 1'b0};
      2'd2: shape = phase_q[15] ? 8'hFF : 8'h00;
      default: begin
`ifdef DAC_SINE_LUT_EN
        if (p[7]) begin
          shape = 8'd128 - {1'b0, sine_lut(p[6] ? ~p[5:0] : p[5:0])};
        end else begin
          shape = 8'd128 + {1'b0, sine_lut(p[6] ? ~p[5:0] : p[5:0])};
        end
`else
        shape = 8'h00;
`endif
      end
    endcase
    sample_d = tick_d1_q ? shape : sample_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      div_q     <= '0;
      phase_q   <= 16'h0000;
      sel_q     <= 2'd0;
      prev_q    <= 1'b1;
      tick_d1_q <= 1'b0;
      sample_q  <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      sel_q     <= sel_d;
      prev_q    <= i_Wave_Next;
      tick_d1_q <= tick;
      sample_q  <= sample_d;
      valid_q   <= tick_d1_q;
    end
  end

  assign o_Sample       = sample_q;
  assign o_Sample_Valid = valid_q;
  assign o_Wave_Sel     = sel_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb/tb_dac_wave_gen.sv - randomized check of dac_wave_gen against a sample-level model
module tb_dac_wave_gen;

  localparam int DIV = 4;
`ifdef DAC_SINE_LUT_EN
  localparam int NWAVES = 4;
`else
  localparam int NWAVES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wave_next;
  logic [7:0] freq_step;
  logic [7:0] sample;
  logic       sample_valid;
  logic [1:0] wave_sel;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc;
  int phase_m;
  int sel_m;
  bit prev_m;
  int last_m;
  int exp_q[$];
  bit wn_cur;

  dac_wave_gen #(.SAMPLE_DIV(DIV)) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Wave_Next    (wave_next),
    .i_Freq_Step    (freq_step),
    .o_Sample       (sample),
    .o_Sample_Valid (sample_valid),
    .o_Wave_Sel     (wave_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int shape_m(input int ph, input int sel);
    int  p;
    int  k;
    int  lut;
    real a;
    p = ph / 256;
    case (sel)
      0: return p;
      1: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2: return (p >= 128) ? 255 : 0;
      default: begin
        k   = ((p % 128) < 64) ? (p % 64) : 63 - (p % 64);
        a   = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / 256.0;
        lut = $rtoi(127.0 * $sin(a) + 0.5);
        return (p >= 128) ? 128 - lut : 128 + lut;
      end
    endcase
  endfunction

  // Called at a falling edge: hold reset n cycles, checking reset outputs, then release.
  task automatic do_reset(input int n, input bit wn);
    rst       = 1'b1;
    wave_next = wn;
    wn_cur    = wn;
    repeat (n) begin
      @(negedge clk);
      check("rst_sample", sample, 8'h00);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_sel", wave_sel, 2'd0);
    end
    rst     = 1'b0;
    cyc     = 0;
    phase_m = 0;
    sel_m   = 0;
    prev_m  = 1'b1;
    last_m  = 0;
    exp_q.delete();
  endtask

  // Observe outputs of the current cycle, drive its inputs, advance the model, move on.
  task automatic one_cycle(input logic [7:0] step, input bit wn);
    bit exp_valid;
    int e;
    exp_valid = (cyc >= DIV + 1) && ((cyc - DIV - 1) % DIV == 0);
    check("valid", sample_valid, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        check("sample_queue", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sample", sample, e);
        last_m = e;
      end
    end else begin
      check("sample_hold", sample, last_m);
    end
    check("wave_sel", wave_sel, sel_m);

    freq_step = step;
    wave_next = wn;
    wn_cur    = wn;
    if (wn && !prev_m) sel_m = (sel_m + 1) % NWAVES;
    prev_m = wn;
    if (cyc % DIV == DIV - 1) begin
      phase_m = (phase_m + step) % 65536;
      exp_q.push_back(shape_m(phase_m, sel_m));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto_sel(input int target, input logic [7:0] step);
    for (int i = 0; i < 8 && sel_m != target; i++) begin
      one_cycle(step, 1'b0);
      one_cycle(step, 1'b1);
    end
  endtask

  task automatic run(input int n, input logic [7:0] step);
    for (int i = 0; i < n; i++) one_cycle(step, wn_cur);
  endtask

  initial begin
    freq_step = 8'h00;
    do_reset(3, 1'b1);

    // Sawtooth past a full phase wrap, switch still held from reset
    run(DIV * 520, 8'h80);

    // Triangle and square with near-maximum step
    goto_sel(1, 8'hFF);
    run(DIV * 300, 8'hFF);
    goto_sel(2, 8'hFF);
    run(DIV * 300, 8'hFF);

    // Five stepped edges through the select sequence
    for (int i = 0; i < 5; i++) begin
      one_cycle(8'h10, 1'b0);
      one_cycle(8'h10, 1'b1);
    end

    // Edge coinciding with a tick
    while (cyc % DIV != DIV - 2) one_cycle(8'h20, 1'b1);
    one_cycle(8'h20, 1'b0);
    one_cycle(8'h20, 1'b1);
    run(DIV * 3, 8'h20);

    // Step 0 holds the phase
    run(DIV * 6, 8'h00);

    // Randomized step and switch activity
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] st;
      bit         w;
      st = 8'($urandom);
      w  = ($urandom_range(0, 3) == 0) ? ~wn_cur : wn_cur;
      one_cycle(st, w);
    end

`ifdef DAC_SINE_LUT_EN
    // Sine: phase walks through 0x4000 and 0xC000 with step 0x40
    goto_sel(3, 8'h40);
    run(DIV * 1100, 8'h40);
`endif

    // Reset in a tick cycle coinciding with a rising edge
    while (cyc % DIV != DIV - 2) one_cycle(8'h33, 1'b1);
    one_cycle(8'h33, 1'b0);
    do_reset(1, 1'b1);
    run(DIV * 12, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
